// File: rtl/exu_pkg.sv
// Shared decode constants, ALU operation encoding, immediate extractors and
// the response payload type for the RV32I execution unit.
package exu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] offset;
    logic        ill;
  } exu_rsp_t;

  function automatic logic [31:0] imm_i(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ir);
    return {ir[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/exu_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// x0 reads as zero and ignores writes.
module exu_regfile import exu_pkg::*; #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int RIW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RIW-1:0] ra1,
  input  logic [RIW-1:0] ra2,
  output logic [DW-1:0]  rd1,
  output logic [DW-1:0]  rd2,
  input  logic           we,
  input  logic [RIW-1:0] wa,
  input  logic [DW-1:0]  wd
);

  logic [DW-1:0] regs_q [NREG];

  // Register array write; reset clears every entry asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/exu_rv.sv
// RV32I execution unit: decodes one instruction per handshake, executes it
// against the register file and returns a registered branch-resolution response.
module exu_rv import exu_pkg::*; #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_vld,
  output logic          req_rdy,
  input  logic [31:0]   req_ir,
  input  logic [AW-1:0] req_pc,
  output logic          rsp_vld,
  input  logic          rsp_rdy,
  output logic          rsp_taken,
  output logic [AW-1:0] rsp_offset,
  output logic          rsp_ill
);

  localparam int         RIW    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0] NREG_L = 6'(NREG);

  logic [6:0]    opcode, funct7;
  logic [4:0]    rd_idx, rs1_idx, rs2_idx;
  logic [2:0]    funct3;
  logic [DW-1:0] rs1_val, rs2_val, imm_i_v, imm_b_v, imm_u_v, imm_j_v;
  logic [DW-1:0] pc_ext, alu_a, alu_b, alu_res, jalr_sum;
  logic          use_rs1, use_rs2, use_rd, is_jal, is_jalr, is_branch, ill_op;
  alu_op_e       alu_op;
  logic          br_eq, br_lt, br_ltu, br_taken;
  logic          xfer_taken, misalign, bad_idx, ill, accept, rf_we;
  logic [AW-1:0] xfer_off, xfer_tgt;
  exu_rsp_t      rsp_new, rsp_d, rsp_q;
  logic          rsp_vld_d, rsp_vld_q;

  assign opcode  = req_ir[6:0];
  assign rd_idx  = req_ir[11:7];
  assign funct3  = req_ir[14:12];
  assign rs1_idx = req_ir[19:15];
  assign rs2_idx = req_ir[24:20];
  assign funct7  = req_ir[31:25];
  assign imm_i_v = imm_i(req_ir);
  assign imm_b_v = imm_b(req_ir);
  assign imm_u_v = imm_u(req_ir);
  assign imm_j_v = imm_j(req_ir);
  assign pc_ext  = DW'(req_pc);

  exu_regfile #(.DW(DW), .NREG(NREG), .RIW(RIW)) u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_idx[RIW-1:0]),
    .ra2 (rs2_idx[RIW-1:0]),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (rf_we),
    .wa  (rd_idx[RIW-1:0]),
    .wd  (alu_res)
  );

  // Instruction decode: operand selection, ALU operation and legality.
  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    ill_op    = 1'b0;
    alu_op    = ALU_ADD;
    alu_a     = rs1_val;
    alu_b     = rs2_val;
    case (opcode)
      OPC_LUI: begin
        use_rd = 1'b1;
        alu_a  = '0;
        alu_b  = imm_u_v;
      end
      OPC_AUIPC: begin
        use_rd = 1'b1;
        alu_a  = pc_ext;
        alu_b  = imm_u_v;
      end
      OPC_JAL: begin
        use_rd = 1'b1;
        is_jal = 1'b1;
        alu_a  = pc_ext;
        alu_b  = DW'(32'd4);
      end
      OPC_JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        is_jalr = 1'b1;
        alu_a   = pc_ext;
        alu_b   = DW'(32'd4);
        ill_op  = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        is_branch = 1'b1;
        ill_op    = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_OP_IMM, OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (opcode == OPC_OP) begin
          use_rs2 = 1'b1;
          ill_op  = !((funct7 == 7'b0000000) ||
                      ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        end else begin
          alu_b = imm_i_v;
        end
        case (funct3)
          3'b000:  alu_op = ((opcode == OPC_OP) && req_ir[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_op = ALU_SLL;
          3'b010:  alu_op = ALU_SLT;
          3'b011:  alu_op = ALU_SLTU;
          3'b100:  alu_op = ALU_XOR;
          3'b101:  alu_op = req_ir[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_FENCE: begin
        use_rd = 1'b0;
      end
      default: begin
        ill_op = 1'b1;
      end
    endcase
  end

  // Integer ALU; shift amounts use only the low five bits.
  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SLT:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? DW'(32'd1) : '0;
      ALU_SLTU: alu_res = (alu_a < alu_b) ? DW'(32'd1) : '0;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = $signed(alu_a) >>> alu_b[4:0];
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      default:  alu_res = alu_a + alu_b;
    endcase
  end

  assign br_eq  = (rs1_val == rs2_val);
  assign br_lt  = ($signed(rs1_val) < $signed(rs2_val));
  assign br_ltu = (rs1_val < rs2_val);

  // Branch condition evaluation.
  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = br_eq;
      F3_BNE:  br_taken = !br_eq;
      F3_BLT:  br_taken = br_lt;
      F3_BGE:  br_taken = !br_lt;
      F3_BLTU: br_taken = br_ltu;
      F3_BGEU: br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_val + imm_i_v;

  // Control-transfer resolution; offset is next-PC minus the request PC.
  always_comb begin
    xfer_taken = 1'b0;
    xfer_off   = AW'(32'd4);
    if (is_jal) begin
      xfer_taken = 1'b1;
      xfer_off   = imm_j_v[AW-1:0];
    end else if (is_jalr) begin
      xfer_taken = 1'b1;
      xfer_off   = {jalr_sum[AW-1:1], 1'b0} - req_pc;
    end else if (is_branch && br_taken) begin
      xfer_taken = 1'b1;
      xfer_off   = imm_b_v[AW-1:0];
    end else begin
      xfer_taken = 1'b0;
      xfer_off   = AW'(32'd4);
    end
  end

  assign xfer_tgt = req_pc + xfer_off;
  assign misalign = xfer_taken & xfer_tgt[1];
  assign bad_idx  = (use_rs1 && ({1'b0, rs1_idx} >= NREG_L)) ||
                    (use_rs2 && ({1'b0, rs2_idx} >= NREG_L)) ||
                    (use_rd  && ({1'b0, rd_idx}  >= NREG_L));
  assign ill      = ill_op | bad_idx | misalign;

  assign req_rdy = ~rsp_vld_q | rsp_rdy;
  assign accept  = req_vld & req_rdy;
  assign rf_we   = accept & use_rd & ~ill;

  // Response payload and output-stage next state.
  always_comb begin
    rsp_new.taken  = xfer_taken & ~ill;
    rsp_new.offset = ill ? 32'd4 : 32'(xfer_off);
    rsp_new.ill    = ill;
    rsp_vld_d      = rsp_vld_q;
    rsp_d          = rsp_q;
    if (accept) begin
      rsp_vld_d = 1'b1;
      rsp_d     = rsp_new;
    end else if (rsp_rdy) begin
      rsp_vld_d = 1'b0;
    end else begin
      rsp_vld_d = rsp_vld_q;
    end
  end

  // Output-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
    end
  end

  assign rsp_vld    = rsp_vld_q;
  assign rsp_taken  = rsp_q.taken;
  assign rsp_offset = rsp_q.offset[AW-1:0];
  assign rsp_ill    = rsp_q.ill;

endmodule

// File: tb/tb_exu_rv.sv
// Scoreboard bench for exu_rv: directed scenarios plus random instructions
// checked against an ISA-level reference model.
module tb_exu_rv;

  localparam int NREG = 16;

  typedef struct {
    logic        taken;
    logic [31:0] off;
    logic        ill;
    logic [31:0] ir;
  } exp_t;

  logic        clk, rst, req_vld, req_rdy, rsp_vld, rsp_rdy, rsp_taken, rsp_ill;
  logic [31:0] req_ir, req_pc, rsp_offset;

  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 0;
  bit          rdy_rand = 0;
  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mregs [32];

  exu_rv #(.DW(32), .AW(32), .NREG(NREG)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_vld    (req_vld),
    .req_rdy    (req_rdy),
    .req_ir     (req_ir),
    .req_pc     (req_pc),
    .rsp_vld    (rsp_vld),
    .rsp_rdy    (rsp_rdy),
    .rsp_taken  (rsp_taken),
    .rsp_offset (rsp_offset),
    .rsp_ill    (rsp_ill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic [31:0] x,
                                      input logic [31:0] y, input logic alt, input bit is_op);
    logic [31:0] r;
    case (f3)
      3'd0: r = (is_op && alt) ? x - y : x + y;
      3'd1: r = x << y[4:0];
      3'd2: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: r = (x < y) ? 32'd1 : 32'd0;
      3'd4: r = x ^ y;
      3'd5: begin
        if (alt) r = $signed(x) >>> y[4:0];
        else     r = x >> y[4:0];
      end
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  // ISA-level model: executes one accepted instruction and updates mregs.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] pc);
    exp_t        e;
    logic [4:0]  rd = ir[11:7], rs1 = ir[19:15], rs2 = ir[24:20];
    logic [2:0]  f3 = ir[14:12];
    logic [6:0]  f7 = ir[31:25];
    logic [31:0] immI = {{20{ir[31]}}, ir[31:20]};
    logic [31:0] immB = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    logic [31:0] immU = {ir[31:12], 12'h000};
    logic [31:0] immJ = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    logic [31:0] a = mregs[rs1], b = mregs[rs2], res = 32'd0, tgt, off = 32'd4;
    bit legal = 1, tk = 0, u1 = 0, u2 = 0, ud = 0;
    case (ir[6:0])
      7'h37: begin ud = 1; res = immU; end
      7'h17: begin ud = 1; res = pc + immU; end
      7'h6F: begin ud = 1; res = pc + 32'd4; tk = 1; off = immJ; end
      7'h67: begin
        ud = 1; u1 = 1; res = pc + 32'd4; tk = 1;
        tgt = (a + immI) & 32'hFFFF_FFFE;
        off = tgt - pc;
        if (f3 != 3'd0) legal = 0;
      end
      7'h63: begin
        u1 = 1; u2 = 1;
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: legal = 0;
        endcase
        if (tk) off = immB;
      end
      7'h13: begin ud = 1; u1 = 1; res = alu(f3, a, immI, ir[30], 0); end
      7'h33: begin
        ud = 1; u1 = 1; u2 = 1;
        res = alu(f3, a, b, ir[30], 1);
        if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) legal = 0;
      end
      7'h0F: ;
      default: legal = 0;
    endcase
    if ((u1 && rs1 >= NREG) || (u2 && rs2 >= NREG) || (ud && rd >= NREG)) legal = 0;
    tgt = pc + off;
    if (tk && tgt[1]) legal = 0;
    if (!legal) begin
      tk  = 0;
      off = 32'd4;
    end else if (ud && rd != 5'd0) begin
      mregs[rd] = res;
    end
    e.taken = tk;
    e.off   = off;
    e.ill   = !legal;
    e.ir    = ir;
    return e;
  endfunction

  // Present one instruction, wait (bounded) for acceptance, queue its expectation.
  task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input bit directed,
                       input logic x_taken, input logic [31:0] x_off, input logic x_ill);
    exp_t e;
    int   n = 0;
    req_vld = 1'b1;
    req_ir  = ir;
    req_pc  = pc;
    #1;
    while (!req_rdy && n < 200) begin
      step();
      #1;
      n++;
    end
    if (!req_rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ir=%h never accepted, req_rdy=%b expected 1", ir, req_rdy);
    end else begin
      e = model(ir, pc);
      if (directed) begin
        e.taken = x_taken;
        e.off   = x_off;
        e.ill   = x_ill;
      end
      q.push_back(e);
    end
    step();
    req_vld = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 15) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, NREG - 1));
  endfunction

  function automatic logic [31:0] gen_ir();
    logic [31:0] r = $urandom();
    int          v;
    case ($urandom_range(0, 11))
      0:  begin r[6:0] = 7'h37; r[11:7] = pick_reg(); end
      1:  begin r[6:0] = 7'h17; r[11:7] = pick_reg(); end
      2, 3: begin
        r[6:0] = 7'h13; r[11:7] = pick_reg(); r[19:15] = pick_reg();
        if ($urandom_range(0, 3) != 0) r[31:25] = {1'b0, r[30], 5'b00000};
      end
      4, 5: begin
        r[6:0] = 7'h33; r[11:7] = pick_reg(); r[19:15] = pick_reg(); r[24:20] = pick_reg();
        v = $urandom_range(0, 7);
        if (v >= 4) r[31:25] = 7'h20;
        else if (v >= 1) r[31:25] = 7'h00;
      end
      6, 7: begin
        r[6:0] = 7'h63; r[19:15] = pick_reg(); r[24:20] = pick_reg();
        if ($urandom_range(0, 3) != 0) r[8] = 1'b0;
      end
      8:  begin
        r[6:0] = 7'h6F; r[11:7] = pick_reg();
        if ($urandom_range(0, 3) != 0) r[21] = 1'b0;
      end
      9:  begin
        r[6:0] = 7'h67; r[11:7] = pick_reg(); r[19:15] = pick_reg();
        if ($urandom_range(0, 5) != 0) r[14:12] = 3'b000;
      end
      10: r[6:0] = 7'h0F;
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: compare the presented response with the queue head; pop when consumed.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (req_rdy !== (!rsp_vld || rsp_rdy)) begin
        errors++;
        $display("FAIL req_rdy: got %b with rsp_vld=%b rsp_rdy=%b", req_rdy, rsp_vld, rsp_rdy);
      end
      if (rsp_vld) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: rsp_vld=1 taken=%b off=%h ill=%b, expected no response",
                   rsp_taken, rsp_offset, rsp_ill);
        end else begin
          mon_e = q[0];
          if (rsp_taken !== mon_e.taken || rsp_offset !== mon_e.off || rsp_ill !== mon_e.ill) begin
            errors++;
            $display("FAIL rsp ir=%h: got taken=%b off=%h ill=%b, expected taken=%b off=%h ill=%b",
                     mon_e.ir, rsp_taken, rsp_offset, rsp_ill, mon_e.taken, mon_e.off, mon_e.ill);
          end
          if (rsp_rdy) void'(q.pop_front());
        end
      end
    end
  end

  // Random response backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) rsp_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] p;
    int          n;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    rst = 1'b1; req_vld = 1'b0; req_ir = 32'd0; req_pc = 32'd0; rsp_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("reset_taken", 32'(rsp_taken), 32'd0);
    chk("reset_offset", rsp_offset, 32'd0);
    chk("reset_ill", 32'(rsp_ill), 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_req_rdy", 32'(req_rdy), 32'd1);
    step();
    mon_en = 1'b1;

    issue(32'h00500093, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x1,x0,5
    issue(32'h00308113, 32'h4, 1, 1'b0, 32'd4, 1'b0);   // ADDI x2,x1,3
    issue(32'h00010863, 32'h8, 1, 1'b0, 32'd4, 1'b0);   // BEQ x2,x0,+16
    issue(32'h00800193, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x3,x0,8
    issue(32'h00310863, 32'h0, 1, 1'b1, 32'd16, 1'b0);  // BEQ x2,x3,+16
    issue(32'h00700093, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x1,x0,7
    issue(32'h00700113, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x2,x0,7
    issue(32'hFE209CE3, 32'h200, 1, 1'b0, 32'd4, 1'b0); // BNE x1,x2,-8
    issue(32'hFE20FCE3, 32'h200, 1, 1'b1, 32'hFFFFFFF8, 1'b0); // BGEU x1,x2,-8
    issue(32'h20100093, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x1,x0,0x201
    issue(32'h010082E7, 32'h100, 1, 1'b1, 32'h110, 1'b0); // JALR x5,x1,0x10
    issue(32'h10400313, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x6,x0,0x104
    issue(32'h00628463, 32'h0, 1, 1'b1, 32'd8, 1'b0);   // BEQ x5,x6,+8
    issue(32'h00000073, 32'h0, 1, 1'b0, 32'd4, 1'b1);   // SYSTEM
    issue(32'h00002063, 32'h0, 1, 1'b0, 32'd4, 1'b1);   // BEQ funct3=010
    issue(32'h00208A33, 32'h0, 1, 1'b0, 32'd4, 1'b1);   // ADD x20,x1,x2 (x20 absent)
    issue(32'h00000313, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x6,x0,0
    step();

    // Backpressure: a held response must block acceptance and register writes.
    rsp_rdy = 1'b0;
    issue(32'h00100393, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x7,x0,1
    req_vld = 1'b1;
    req_ir  = 32'h06300313;                             // ADDI x6,x0,99 (not accepted)
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req_rdy", 32'(req_rdy), 32'd0);
      step();
    end
    req_ir  = 32'h00130313;                             // ADDI x6,x6,1
    rsp_rdy = 1'b1;
    #1;
    chk("release_req_rdy", 32'(req_rdy), 32'd1);
    issue(32'h00130313, 32'h0, 1, 1'b0, 32'd4, 1'b0);
    issue(32'h00730463, 32'h0, 1, 1'b1, 32'd8, 1'b0);   // BEQ x6,x7,+8
    step();

    // Reset while a response is pending.
    rsp_rdy = 1'b0;
    issue(32'h00500093, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADDI x1,x0,5
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midreset_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("midreset_req_rdy", 32'(req_rdy), 32'd1);
    q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    step();
    rst = 1'b0;
    rsp_rdy = 1'b1;
    mon_en = 1'b1;
    issue(32'h000081B3, 32'h0, 1, 1'b0, 32'd4, 1'b0);   // ADD x3,x1,x0
    issue(32'h00018463, 32'h0, 1, 1'b1, 32'd8, 1'b0);   // BEQ x3,x0,+8

    rdy_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) step();
      p = $urandom();
      p[1:0] = 2'b00;
      issue(gen_ir(), p, 0, 1'b0, 32'd0, 1'b0);
    end
    rdy_rand = 1'b0;
    step();
    rsp_rdy = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_queue", 32'(q.size()), 32'd0);
    step();
    chk("drain_rsp_vld", 32'(rsp_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exu_rv.md
# exu_rv

Parametrised RV32I execution unit for the core: accepts one instruction per handshake from the IFU, executes integer ALU, LUI/AUIPC and control-transfer instructions against an internal register file, and returns a registered branch-resolution response (taken, PC-relative offset, illegal flag). It replaces the fixed-response executor, adding real operand decode, a register file, and response backpressure.

## Interface
- `DW`, 32: datapath/register width (XLEN); only 32 is supported.
- `AW`, 32: PC and offset width; `AW <= DW`.
- `NREG`, 32: architectural registers; 32 (RV32I) or 16 (RV32E).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `req_vld` in 1: IFU presents an instruction.
- `req_rdy` out 1: EXU can accept.
- `req_ir` in 32: instruction word.
- `req_pc` in AW: PC of `req_ir`.
- `rsp_vld` out 1: response valid.
- `rsp_rdy` in 1: IFU consumes the response.
- `rsp_taken` out 1: control transfer taken.
- `rsp_offset` out AW: next-PC minus `req_pc`, two's complement.
- `rsp_ill` out 1: instruction illegal or faulting; no architectural effect.

## Operation
- Accept: `req_vld & req_rdy`. `req_rdy = ~rsp_vld | rsp_rdy` (combinational, one-entry output stage).
- Decode and register reads are combinational on `req_ir`. Writeback and response-register load both occur on the accept edge, so a dependent instruction accepted next cycle reads the updated value; no forwarding is needed.
- x0 reads 0; writes to x0 are discarded.
- LUI, AUIPC, OP-IMM, OP (no M-extension) write rd. Response: `taken=0`, `offset=4`.
- JAL: rd <= pc+4; `taken=1`; `offset` = imm_J.
- JALR (funct3 = 000): target = (rs1 + imm_I) & ~1; rd <= pc+4; `taken=1`; `offset = target - pc`, modulo 2^AW.
- BRANCH with funct3 in {000, 001, 100, 101, 110, 111}:
  - Signed/unsigned compare of rs1 and rs2.
  - Taken: `taken=1`, `offset` = imm_B.
  - Not taken: `taken=0`, `offset=4`.
- FENCE: no-op; `taken=0`, `offset=4`.
- `rsp_ill=1` with `taken=0`, `offset=4` and no register write in any of these cases:
  - any other opcode;
  - BRANCH funct3 010/011;
  - JALR funct3 != 000;
  - any rs1/rs2/rd index >= NREG;
  - a taken target with bit 1 set (misaligned).
- Shifts use only the low 5 bits of the shift amount. SRAI/SRA are selected by instr[30]. OP with an illegal funct7 is illegal.
- Arithmetic wraps modulo 2^DW.

## Timing
- Latency: response visible the cycle after accept. Throughput: 1 instruction/cycle while `rsp_rdy=1`.
- `rsp_vld` stays high with stable payload until `rsp_rdy`.
- Response consumed and new request accepted in the same cycle: payload is replaced with no bubble.
- `rsp_vld=0` with `req_vld=1`: accept immediately.
- `rsp_vld=1`, `rsp_rdy=0`: `req_rdy=0`; the register file is not written.
- Reset values:
  - `rsp_vld=0`, `rsp_taken=0`, `rsp_offset=0`, `rsp_ill=0`.
  - All registers = 0.
  - `req_rdy` = 1 combinationally once reset is released.
- Reset mid-operation: a pending response is dropped, and register contents return to 0 asynchronously.

## Structure
- `exu_pkg` holds:
  - opcode constants (LUI, AUIPC, JAL, JALR, BRANCH, OP_IMM, OP, FENCE);
  - branch funct3 constants;
  - `alu_op_e` enum;
  - immediate-extraction functions (I/S/B/U/J);
  - `exu_rsp_t` struct {taken, offset, ill}.
- Sub-module `exu_regfile`: NREG x DW, two combinational read ports, one write port, async active-high reset, x0 hardwired to zero.
- The top level holds decode, ALU, branch compare and the output stage.

## Test plan
- After reset, `rsp_vld=0` and `req_rdy=1`. Then issue ADDI x1,x0,5 followed next cycle by ADDI x2,x1,3, with `rsp_rdy=1`:
  - two responses, each `taken=0`, `offset=4`, `ill=0`;
  - a following BEQ x2,x0,+16 responds `taken=0`, `offset=4`, so x2 = 8.
- Set x1=7, x2=7 and issue BNE x1,x2,-8 → `taken=0`, `offset=4`. BGEU x1,x2,-8 → `taken=1`, `offset=0xFFFFFFF8`.
- JALR x5,x1,0x10 at pc=0x100 with x1=0x201 → target 0x210, `offset=0x110`, `taken=1`, x5=0x104.
- Hold `rsp_rdy=0` for 3 cycles after the first accept:
  - `req_rdy=0` and the payload stays stable;
  - a second queued ADDI does not write its rd until `rsp_rdy` rises, then is accepted the same cycle.
- Opcode 0x73 (SYSTEM), BEQ with funct3 010, and (NREG=16) ADD x20,x1,x2 → each gives `ill=1`, `taken=0`, `offset=4`, with no register change.
- Assert `rst` while `rsp_vld=1` → `rsp_vld` drops immediately; afterwards x1 reads back 0 (ADD x3,x1,x0 then BEQ x3,x0,+8 → `taken=1`, `offset=8`).
